// File: rtl/lenet_layer_scheduler_if.sv
// ---------------------------------------------------------------------------
// lenet_layer_scheduler_if
//
// Purpose: bundles the control/status signals of the LeNet layer scheduler.
//
// Signals:
//   inference_start   level run request (rising edge starts a run)
//   weight_ready      weights for the network are loaded
//   adc_tvalid        one result beat from the photonic path
//   slack_cycles[15:0] photonic settling wait per layer (0 behaves as 1)
//   layer[2:0]        active layer 0..3
//   state_changed     one-cycle pulse on entry into a new layer
//   integration_start one-cycle pulse when a layer starts integrating
//   reset_all         one-cycle pulse when a run is torn down
//   busy              scheduler is inside a run
//   done              all three layers completed
//   timeout_err       sticky watchdog flag
//   latency_count[31:0] cycles from start to done
//
// Modports:
//   master  - the controller/host side driving requests
//   slave   - the scheduler side
// ---------------------------------------------------------------------------
interface lenet_layer_scheduler_if;
    logic        inference_start;
    logic        weight_ready;
    logic        adc_tvalid;
    logic [15:0] slack_cycles;
    logic [2:0]  layer;
    logic        state_changed;
    logic        integration_start;
    logic        reset_all;
    logic        busy;
    logic        done;
    logic        timeout_err;
    logic [31:0] latency_count;

    modport master (
        output inference_start,
        output weight_ready,
        output adc_tvalid,
        output slack_cycles,
        input  layer,
        input  state_changed,
        input  integration_start,
        input  reset_all,
        input  busy,
        input  done,
        input  timeout_err,
        input  latency_count
    );

    modport slave (
        input  inference_start,
        input  weight_ready,
        input  adc_tvalid,
        input  slack_cycles,
        output layer,
        output state_changed,
        output integration_start,
        output reset_all,
        output busy,
        output done,
        output timeout_err,
        output latency_count
    );
endinterface

// File: rtl/lenet_layer_scheduler.sv
// ---------------------------------------------------------------------------
// lenet_layer_scheduler
//
// Purpose: sequences a three-layer LeNet inference on the photonic engine.
//   IDLE -> WAIT_WEIGHT -> (SLACK -> RUN) x3 -> DONE -> IDLE
//   Each layer waits max(slack_cycles,1) settling cycles, then counts ADC
//   result beats until the layer's beat total is reached.
//
// Ports:
//   clk    single clock
//   rst_n  asynchronous active-low reset
//   bus    lenet_layer_scheduler_if.slave (see interface header)
//
// Parameters:
//   LAYER_1_ALL_CYCLE / LAYER_2_ALL_CYCLE / LAYER_3_ALL_CYCLE
//          ADC beats that close layers 1..3
//   TIMEOUT_CYCLES  consecutive beat-free RUN cycles before the watchdog trips
//
// Build option:
//   LENET_SCHED_WATCHDOG_EN  when defined, a RUN-state watchdog aborts the run
//                            and sets the sticky timeout_err flag; when not
//                            defined, timeout_err is tied low and RUN waits
//                            indefinitely.
// ---------------------------------------------------------------------------
module lenet_layer_scheduler #(
    parameter int LAYER_1_ALL_CYCLE = 14700,
    parameter int LAYER_2_ALL_CYCLE = 1900,
    parameter int LAYER_3_ALL_CYCLE = 70,
    parameter int TIMEOUT_CYCLES    = 4096
) (
    input  logic                    clk,
    input  logic                    rst_n,
    lenet_layer_scheduler_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_WEIGHT,
        ST_SLACK,
        ST_RUN,
        ST_DONE
    } state_t;

    localparam logic [15:0] LAYER_LIMIT [3] = '{
        16'(LAYER_1_ALL_CYCLE),
        16'(LAYER_2_ALL_CYCLE),
        16'(LAYER_3_ALL_CYCLE)
    };

    // Elaboration-time sanity check on the configuration.
    generate
        if (LAYER_1_ALL_CYCLE < 1 || LAYER_2_ALL_CYCLE < 1 ||
            LAYER_3_ALL_CYCLE < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
            $error("lenet_layer_scheduler: beat totals and timeout must be >= 1");
        end
    endgenerate

    state_t      state_reg;
    logic        start_d_reg;
    logic [2:0]  layer_reg;
    logic        state_changed_reg;
    logic        integration_start_reg;
    logic        reset_all_reg;
    logic        busy_reg;
    logic        done_reg;
    logic [31:0] latency_reg;
    logic [15:0] slack_cnt_reg;
    logic [15:0] beat_cnt_reg;

    logic        start_edge;
    logic [15:0] slack_target;
    logic        slack_last;
    logic [15:0] beat_next;
    logic [2:0]  layer_hit;
    logic        layer_end;
    logic [31:0] latency_next;
    logic        teardown;

`ifdef LENET_SCHED_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] idle_cnt_reg;
    logic            timeout_err_reg;
    logic            wd_expire;

    // Trips on the cycle that would make the idle run TIMEOUT_CYCLES long.
    assign wd_expire = (state_reg == ST_RUN) && !bus.adc_tvalid &&
                       (idle_cnt_reg == WD_W'(TIMEOUT_CYCLES - 1));
    assign teardown  = !bus.inference_start || wd_expire;
    assign bus.timeout_err = timeout_err_reg;
`else
    assign teardown  = !bus.inference_start;
    assign bus.timeout_err = 1'b0;
`endif

    // A start needs an observed 0 followed by 1.
    assign start_edge   = bus.inference_start && !start_d_reg;
    assign slack_target = (bus.slack_cycles == 16'd0) ? 16'd1 : bus.slack_cycles;
    assign slack_last   = (slack_cnt_reg == slack_target - 16'd1);
    assign beat_next    = beat_cnt_reg + 16'd1;
    assign latency_next = (latency_reg == 32'hFFFF_FFFF) ? latency_reg
                                                         : latency_reg + 32'd1;

    // One comparator per layer; only the active layer's can fire.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_layer_hit
            assign layer_hit[gi] = (layer_reg == 3'(gi + 1)) &&
                                   (beat_next == LAYER_LIMIT[gi]);
        end
    endgenerate
    assign layer_end = |layer_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg             <= ST_IDLE;
            // Reset to 1 so a level held high across reset release is not
            // mistaken for a fresh start request.
            start_d_reg           <= 1'b1;
            layer_reg             <= 3'd0;
            state_changed_reg     <= 1'b0;
            integration_start_reg <= 1'b0;
            reset_all_reg         <= 1'b0;
            busy_reg              <= 1'b0;
            done_reg              <= 1'b0;
            latency_reg           <= 32'd0;
            slack_cnt_reg         <= 16'd0;
            beat_cnt_reg          <= 16'd0;
`ifdef LENET_SCHED_WATCHDOG_EN
            idle_cnt_reg          <= '0;
            timeout_err_reg       <= 1'b0;
`endif
        end else begin
            start_d_reg           <= bus.inference_start;
            state_changed_reg     <= 1'b0;
            integration_start_reg <= 1'b0;
            reset_all_reg         <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    if (start_edge) begin
                        state_reg     <= ST_WAIT_WEIGHT;
                        busy_reg      <= 1'b1;
                        latency_reg   <= 32'd0;
                        slack_cnt_reg <= 16'd0;
                        beat_cnt_reg  <= 16'd0;
`ifdef LENET_SCHED_WATCHDOG_EN
                        idle_cnt_reg    <= '0;
                        timeout_err_reg <= 1'b0;
`endif
                    end
                end

                ST_WAIT_WEIGHT, ST_SLACK, ST_RUN: begin
                    if (teardown) begin
                        // Abort (or watchdog) beats any layer step or final
                        // beat landing on the same cycle.
                        state_reg     <= ST_IDLE;
                        reset_all_reg <= 1'b1;
                        layer_reg     <= 3'd0;
                        busy_reg      <= 1'b0;
                        done_reg      <= 1'b0;
                        slack_cnt_reg <= 16'd0;
                        beat_cnt_reg  <= 16'd0;
`ifdef LENET_SCHED_WATCHDOG_EN
                        idle_cnt_reg  <= '0;
                        if (bus.inference_start)
                            timeout_err_reg <= 1'b1;
`endif
                    end else begin
                        latency_reg <= latency_next;
                        case (state_reg)
                            ST_WAIT_WEIGHT: begin
                                if (bus.weight_ready) begin
                                    layer_reg         <= 3'd1;
                                    state_changed_reg <= 1'b1;
                                    slack_cnt_reg     <= 16'd0;
                                    state_reg         <= ST_SLACK;
                                end
                            end
                            ST_SLACK: begin
                                // adc_tvalid is deliberately ignored here.
                                if (slack_last) begin
                                    integration_start_reg <= 1'b1;
                                    beat_cnt_reg          <= 16'd0;
                                    state_reg             <= ST_RUN;
`ifdef LENET_SCHED_WATCHDOG_EN
                                    idle_cnt_reg          <= '0;
`endif
                                end else begin
                                    slack_cnt_reg <= slack_cnt_reg + 16'd1;
                                end
                            end
                            default: begin // ST_RUN
                                if (bus.adc_tvalid) begin
`ifdef LENET_SCHED_WATCHDOG_EN
                                    idle_cnt_reg <= '0;
`endif
                                    if (layer_end) begin
                                        beat_cnt_reg <= 16'd0;
                                        if (layer_reg == 3'd3) begin
                                            state_reg <= ST_DONE;
                                            done_reg  <= 1'b1;
                                            busy_reg  <= 1'b0;
                                        end else begin
                                            layer_reg         <= layer_reg + 3'd1;
                                            state_changed_reg <= 1'b1;
                                            slack_cnt_reg     <= 16'd0;
                                            state_reg         <= ST_SLACK;
                                        end
                                    end else begin
                                        beat_cnt_reg <= beat_next;
                                    end
                                end
`ifdef LENET_SCHED_WATCHDOG_EN
                                else begin
                                    idle_cnt_reg <= idle_cnt_reg + 1'b1;
                                end
`endif
                            end
                        endcase
                    end
                end

                ST_DONE: begin
                    layer_reg <= 3'd3;
                    if (!bus.inference_start) begin
                        state_reg     <= ST_IDLE;
                        reset_all_reg <= 1'b1;
                        layer_reg     <= 3'd0;
                        done_reg      <= 1'b0;
                    end
                end

                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                    layer_reg <= 3'd0;
                end
            endcase
        end
    end

    assign bus.layer             = layer_reg;
    assign bus.state_changed     = state_changed_reg;
    assign bus.integration_start = integration_start_reg;
    assign bus.reset_all         = reset_all_reg;
    assign bus.busy              = busy_reg;
    assign bus.done              = done_reg;
    assign bus.latency_count     = latency_reg;

endmodule

// File: tb/tb_lenet_layer_scheduler.sv
// ---------------------------------------------------------------------------
// tb_lenet_layer_scheduler
//
// Directed bench for lenet_layer_scheduler with LAYER_n_ALL_CYCLE = 4,3,2 and
// TIMEOUT_CYCLES = 8. Inputs change 1 ns after a rising edge; outputs are
// sampled at the same point. "tick N" means the sample after the N-th edge
// counted from when a scenario raises inference_start.
// Watchdog expectations follow LENET_SCHED_WATCHDOG_EN.
// ---------------------------------------------------------------------------
module tb_lenet_layer_scheduler;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lenet_layer_scheduler_if bus ();

    lenet_layer_scheduler #(
        .LAYER_1_ALL_CYCLE (4),
        .LAYER_2_ALL_CYCLE (3),
        .LAYER_3_ALL_CYCLE (2),
        .TIMEOUT_CYCLES    (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_total = 0;
    int n_bad   = 0;
    int tick_no = 0;
    int busy_n  = 0;
    int consec_bad = 0;
    int sc_q[$];
    int sc_lay_q[$];
    int int_q[$];
    int ra_q[$];
    logic prev_sc = 1'b0;
    logic prev_int = 1'b0;
    logic prev_ra = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    function automatic int q_at(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic clear_log();
        tick_no = 0;
        busy_n  = 0;
        sc_q.delete();
        sc_lay_q.delete();
        int_q.delete();
        ra_q.delete();
    endtask

    // Advance one edge and log pulse events against the scenario tick.
    task automatic tick();
        @(posedge clk);
        #1;
        tick_no++;
        if (bus.busy) busy_n++;
        if (bus.state_changed) begin
            sc_q.push_back(tick_no);
            sc_lay_q.push_back(int'(bus.layer));
        end
        if (bus.integration_start) int_q.push_back(tick_no);
        if (bus.reset_all) ra_q.push_back(tick_no);
        if ((bus.state_changed && prev_sc) || (bus.integration_start && prev_int) ||
            (bus.reset_all && prev_ra))
            consec_bad++;
        prev_sc  = bus.state_changed;
        prev_int = bus.integration_start;
        prev_ra  = bus.reset_all;
    endtask

    initial begin
        #200000;
        $display("FAIL sim_timeout got=running exp=finished");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        bus.inference_start = 1'b0;
        bus.weight_ready    = 1'b0;
        bus.adc_tvalid      = 1'b0;
        bus.slack_cycles    = 16'd2;

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_layer", 32'(bus.layer), 0);
        check_val("rst_busy_done", {30'd0, bus.busy, bus.done}, 0);
        check_val("rst_pulses", {29'd0, bus.state_changed, bus.integration_start, bus.reset_all}, 0);
        check_val("rst_timeout", 32'(bus.timeout_err), 0);
        check_val("rst_latency", bus.latency_count, 0);
        rst_n = 1'b1;
        tick();
        tick();

        // ---------------- watchdog scenario ----------------
        // Two beats in layer 1, then silence: idle cycles at edges 7..14.
        clear_log();
        bus.slack_cycles    = 16'd2;
        bus.weight_ready    = 1'b1;
        bus.adc_tvalid      = 1'b0;
        bus.inference_start = 1'b1;
        while (tick_no < 14) begin
            if (tick_no == 4) bus.adc_tvalid = 1'b1;
            if (tick_no == 6) bus.adc_tvalid = 1'b0;
            tick();
            if (tick_no == 13) check_val("wd_not_early", 32'(bus.timeout_err), 0);
        end
`ifdef LENET_SCHED_WATCHDOG_EN
        check_val("wd_timeout_err", 32'(bus.timeout_err), 1);
        check_val("wd_reset_all", 32'(bus.reset_all), 1);
        check_val("wd_busy", 32'(bus.busy), 0);
        check_val("wd_layer", 32'(bus.layer), 0);
`else
        check_val("wd_timeout_err", 32'(bus.timeout_err), 0);
        check_val("wd_reset_all", 32'(bus.reset_all), 0);
        check_val("wd_busy", 32'(bus.busy), 1);
        check_val("wd_layer", 32'(bus.layer), 1);
`endif
        bus.inference_start = 1'b0;
        tick();
        check_val("wd_after_busy", 32'(bus.busy), 0);
`ifdef LENET_SCHED_WATCHDOG_EN
        check_val("wd_after_ra", 32'(bus.reset_all), 0);
`else
        check_val("wd_after_ra", 32'(bus.reset_all), 1);
`endif
        tick();

        // ---------------- full run, slack=2 ----------------
        clear_log();
        bus.weight_ready    = 1'b0;
        bus.adc_tvalid      = 1'b1;
        bus.slack_cycles    = 16'd2;
        bus.inference_start = 1'b1;
        while (!bus.done && tick_no < 40) begin
            if (tick_no == 3) bus.weight_ready = 1'b1;
            tick();
            if (tick_no == 1) check_val("run1_timeout_cleared", 32'(bus.timeout_err), 0);
        end
        check_val("run1_done_tick", tick_no, 19);
        check_val("run1_sc_count", sc_q.size(), 3);
        check_val("run1_sc0_tick", q_at(sc_q, 0), 4);
        check_val("run1_sc1_tick", q_at(sc_q, 1), 10);
        check_val("run1_sc2_tick", q_at(sc_q, 2), 15);
        check_val("run1_sc_layers", (q_at(sc_lay_q, 0) * 100) + (q_at(sc_lay_q, 1) * 10) + q_at(sc_lay_q, 2), 123);
        check_val("run1_int0_tick", q_at(int_q, 0), 6);
        check_val("run1_int1_tick", q_at(int_q, 1), 12);
        check_val("run1_int2_tick", q_at(int_q, 2), 17);
        check_val("run1_latency", bus.latency_count, 18);
        check_val("run1_busy_cycles", busy_n, 18);
        tick();
        check_val("done_hold", {30'd0, bus.done, bus.busy}, 2);
        check_val("done_layer", 32'(bus.layer), 3);
        bus.inference_start = 1'b0;
        tick();
        check_val("done_exit_ra", 32'(bus.reset_all), 1);
        check_val("done_exit_done", 32'(bus.done), 0);
        check_val("done_exit_layer", 32'(bus.layer), 0);
        check_val("done_exit_latency", bus.latency_count, 18);
        tick();
        check_val("done_exit_ra_single", 32'(bus.reset_all), 0);

        // ---------------- slack=0, abort on layer-2 beat 3 ----------------
        clear_log();
        bus.slack_cycles    = 16'd0;
        bus.weight_ready    = 1'b1;
        bus.adc_tvalid      = 1'b1;
        bus.inference_start = 1'b1;
        tick();
        check_val("run2_latency_clear", bus.latency_count, 0);
        check_val("run2_busy", 32'(bus.busy), 1);
        while (tick_no < 10) tick();
        bus.inference_start = 1'b0;
        tick();
        check_val("abort_ra", 32'(bus.reset_all), 1);
        check_val("abort_state", {28'd0, bus.layer, bus.done}, 0);
        check_val("abort_no_sc", 32'(bus.state_changed), 0);
        check_val("abort_busy", 32'(bus.busy), 0);
        tick();
        check_val("abort_ra_count", ra_q.size(), 1);
        check_val("run2_sc_count", sc_q.size(), 2);
        check_val("run2_sc1_tick", q_at(sc_q, 1), 7);
        check_val("run2_int0_tick", q_at(int_q, 0), 3);
        check_val("run2_int1_tick", q_at(int_q, 1), 8);

        // ---------------- reset during layer 2 ----------------
        clear_log();
        bus.slack_cycles    = 16'd2;
        bus.weight_ready    = 1'b1;
        bus.adc_tvalid      = 1'b1;
        bus.inference_start = 1'b1;
        while (tick_no < 11) tick();
        check_val("rmid_layer_before", 32'(bus.layer), 2);
        rst_n = 1'b0;
        #1;
        check_val("rmid_layer", 32'(bus.layer), 0);
        check_val("rmid_busy", 32'(bus.busy), 0);
        check_val("rmid_latency", bus.latency_count, 0);
        check_val("rmid_ra", 32'(bus.reset_all), 0);
        tick();
        tick();
        rst_n = 1'b1;
        clear_log();
        repeat (5) tick();
        check_val("rmid_no_restart", busy_n, 0);
        check_val("rmid_no_ra", ra_q.size(), 0);
        bus.inference_start = 1'b0;
        tick();
        bus.inference_start = 1'b1;
        tick();
        check_val("rmid_fresh_edge", 32'(bus.busy), 1);
        bus.inference_start = 1'b0;
        tick();
        tick();

        check_val("pulse_single_cycle", consec_bad, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
